// File: rtl/fb_write_ctl.sv
// Frame-buffer write controller: buffers PPU pixels and streams them to the frame buffer in raster order, or fills the buffer with one code.
// Latency: a pixel accepted into an empty buffer is written two clock edges later; steady-state throughput is one pixel per cycle.
// Backpressure: pix_ready is low when the buffer is full, while a clear is pending or running, during frame_start, and during reset.
module fb_write_ctl #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_W       = 256,
    parameter int FB_H       = 240
) (
    input  logic       ppu_ctl_clk,
    input  logic       rst,
    input  logic       pix_valid,
    input  logic [5:0] pix_code,
    output logic       pix_ready,
    input  logic       frame_start,
    input  logic       clr_req,
    input  logic [5:0] clr_code,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [7:0] fb_ptr_x,
    output logic [7:0] fb_ptr_y,
    output logic [5:0] fb_DI,
    output logic       fb_CS,
    output logic       frame_done
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]    X_LAST   = 8'(FB_W - 1);
    localparam logic [7:0]    Y_LAST   = 8'(FB_H - 1);

    // Controller states: streaming pixels, or filling the whole buffer.
    localparam logic [0:0]    ST_RUN   = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;

    // Control state
    logic [0:0]    state_q, state_d;
    logic          clr_pend_q, clr_pend_d;
    logic [5:0]    clr_code_q, clr_code_d;
    logic [7:0]    sx_q, sx_d;
    logic [7:0]    sy_q, sy_d;

    // Pixel buffer
    logic [5:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    // Stage between buffer pop and the frame-buffer output register
    logic          stg_vld_q, stg_vld_d;
    logic [5:0]    stg_code_q, stg_code_d;
    logic [7:0]    stg_x_q, stg_x_d;
    logic [7:0]    stg_y_q, stg_y_d;
    logic          stg_last_q, stg_last_d;

    // Registered frame-buffer outputs
    logic          cs_q, cs_d;
    logic [5:0]    di_q, di_d;
    logic [7:0]    px_q, px_d;
    logic [7:0]    py_q, py_d;
    logic          fdone_q, fdone_d;
    logic          cdone_q, cdone_d;

    // Decoded conditions
    logic          in_run;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          flush;
    logic          clr_accept;
    logic          clr_enter;
    logic          x_last;
    logic          y_last;
    logic          at_last;
    logic [7:0]    nx;
    logic [7:0]    ny;

    assign in_run     = (state_q == ST_RUN);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);

    // A pixel offered together with frame_start is refused, so the flush never races a push.
    assign pix_ready  = !rst && in_run && !fifo_full && !clr_pend_q && !frame_start;
    assign push       = pix_valid && pix_ready;
    assign flush      = in_run && frame_start;
    assign pop        = in_run && !flush && !fifo_empty;

    // clr_busy low implies RUN, so a request is taken only when idle in RUN.
    assign clr_busy   = clr_pend_q || !in_run;
    assign clr_accept = clr_req && !clr_busy;
    // A pending clear starts once every queued pixel has left the buffer.
    assign clr_enter  = in_run && clr_pend_q && fifo_empty;

    assign x_last     = (sx_q == X_LAST);
    assign y_last     = (sy_q == Y_LAST);
    assign at_last    = x_last && y_last;

    // Raster successor of the current position, shared by stream and clear.
    always_comb begin
        nx = sx_q + 8'd1;
        ny = sy_q;
        if (x_last) begin
            nx = 8'd0;
            ny = y_last ? 8'd0 : (sy_q + 8'd1);
        end
    end

    // Buffer pointer and occupancy bookkeeping; frame_start discards everything queued.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State, pending-clear flag and the shared position counters.
    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        clr_code_d = clr_code_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        if (!in_run) begin
            // Clearing: one address per cycle; frame_start and clr_req are ignored here.
            sx_d = nx;
            sy_d = ny;
            if (at_last) begin
                state_d    = ST_RUN;
                clr_pend_d = 1'b0;
            end
        end else begin
            if (clr_accept) begin
                clr_pend_d = 1'b1;
                clr_code_d = clr_code;
            end
            if (flush || clr_enter) begin
                sx_d = 8'd0;
                sy_d = 8'd0;
            end else if (pop) begin
                sx_d = nx;
                sy_d = ny;
            end
            if (clr_enter) begin
                state_d = ST_CLEAR;
            end
        end
    end

    // The popped pixel picks up its address here, so counters advance exactly once per pixel.
    always_comb begin
        stg_vld_d  = pop;
        stg_code_d = mem_q[rd_ptr_q];
        stg_x_d    = sx_q;
        stg_y_d    = sy_q;
        stg_last_d = at_last;
    end

    // Select the write for this edge: clear fill, staged pixel, or nothing.
    always_comb begin
        cs_d    = 1'b0;
        di_d    = di_q;
        px_d    = px_q;
        py_d    = py_q;
        fdone_d = 1'b0;
        cdone_d = 1'b0;
        if (!in_run) begin
            cs_d    = 1'b1;
            di_d    = clr_code_q;
            px_d    = sx_q;
            py_d    = sy_q;
            cdone_d = at_last;
        end else if (!flush && stg_vld_q) begin
            cs_d    = 1'b1;
            di_d    = stg_code_q;
            px_d    = stg_x_q;
            py_d    = stg_y_q;
            fdone_d = stg_last_q;
        end
    end

    // Pixel storage; contents are meaningless while empty, so no reset is needed.
    always_ff @(posedge ppu_ctl_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pix_code;
        end
    end

    // All control and output registers, with synchronous reset that also aborts a clear.
    always_ff @(posedge ppu_ctl_clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            clr_pend_q <= 1'b0;
            clr_code_q <= 6'd0;
            sx_q       <= 8'd0;
            sy_q       <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            stg_vld_q  <= 1'b0;
            stg_code_q <= 6'd0;
            stg_x_q    <= 8'd0;
            stg_y_q    <= 8'd0;
            stg_last_q <= 1'b0;
            cs_q       <= 1'b0;
            di_q       <= 6'd0;
            px_q       <= 8'd0;
            py_q       <= 8'd0;
            fdone_q    <= 1'b0;
            cdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            clr_code_q <= clr_code_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            stg_vld_q  <= stg_vld_d;
            stg_code_q <= stg_code_d;
            stg_x_q    <= stg_x_d;
            stg_y_q    <= stg_y_d;
            stg_last_q <= stg_last_d;
            cs_q       <= cs_d;
            di_q       <= di_d;
            px_q       <= px_d;
            py_q       <= py_d;
            fdone_q    <= fdone_d;
            cdone_q    <= cdone_d;
        end
    end

    assign fb_CS      = cs_q;
    assign fb_DI      = di_q;
    assign fb_ptr_x   = px_q;
    assign fb_ptr_y   = py_q;
    assign frame_done = fdone_q;
    assign clr_done   = cdone_q;

    // Structural invariants: completion pulses only ride on a write, and never together.
    a_fdone_cs: assert property (@(posedge ppu_ctl_clk) disable iff (rst) frame_done |-> fb_CS);
    a_cdone_cs: assert property (@(posedge ppu_ctl_clk) disable iff (rst) clr_done |-> fb_CS);
    a_pulse_ex: assert property (@(posedge ppu_ctl_clk) disable iff (rst) !(frame_done && clr_done));
    a_cnt_rng:  assert property (@(posedge ppu_ctl_clk) disable iff (rst) cnt_q <= CNT_FULL);

endmodule
